add8_result_fifo: RTL

ADD8_RESULT_FIFO -- requirements
Module: add8_result_fifo

---
 rtl/add8_result_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/add8_result_fifo.sv
// add8_result_fifo: result FIFO behind a hybrid 8-bit adder.
// Each entry holds the sum, the carry-out and (optionally) the signed-overflow flag.
// Optional feature macro: ADD8_RES_OVF_EN. When it is defined, overflow is computed
// and stored with each entry. When it is undefined, out_ovf is tied low and the
// operand MSB inputs are ignored.
// The head entry is held in output registers, so the outputs never depend
// combinationally on the inputs. The outputs keep the last head value when the
// FIFO is empty.

module add8_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_s,
  input  logic                         in_c8,
  input  logic                         in_xmsb,
  input  logic                         in_ymsb,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_s,
  output logic                         out_c8,
  output logic                         out_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [PW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CW-1:0] count_q, count_next;
  logic          push, pop;

  logic [7:0]    mem_s  [DEPTH];
  logic          mem_c8 [DEPTH];

  logic [7:0]    head_s_q, head_s_next;
  logic          head_c8_q, head_c8_next;
  logic          head_ovf_q, head_ovf_next;

  // Ready/valid come only from the registered occupancy.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_s  = head_s_q;
  assign out_c8 = head_c8_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef ADD8_RES_OVF_EN
  logic in_ovf;
  logic mem_ovf [DEPTH];

  // Signed overflow: operands agree in sign but the sum does not.
  assign in_ovf  = (in_xmsb == in_ymsb) && (in_s[7] != in_xmsb);
  assign out_ovf = head_ovf_q;

  // Overflow storage, written alongside the sum and carry.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem_ovf[wr_ptr] <= in_ovf;
    end
  end
`else
  logic unused_msb;

  assign unused_msb = in_xmsb ^ in_ymsb;
  assign out_ovf    = 1'b0;
`endif

  // Pointer and occupancy next-state.
  always_comb begin
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count_q;
    if (pop) begin
      rd_next = ptr_inc(rd_ptr);
    end
    if (push) begin
      wr_next = ptr_inc(wr_ptr);
    end
    case ({push, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Next head value: the newly pushed entry when it lands at the new read
  // pointer, otherwise the stored entry there; hold when becoming empty.
  always_comb begin
    head_s_next   = head_s_q;
    head_c8_next  = head_c8_q;
    head_ovf_next = head_ovf_q;
    if (count_next != '0) begin
      if (push && (rd_next == wr_ptr)) begin
        head_s_next  = in_s;
        head_c8_next = in_c8;
`ifdef ADD8_RES_OVF_EN
        head_ovf_next = in_ovf;
`else
        head_ovf_next = 1'b0;
`endif
      end else begin
        head_s_next  = mem_s[rd_next];
        head_c8_next = mem_c8[rd_next];
`ifdef ADD8_RES_OVF_EN
        head_ovf_next = mem_ovf[rd_next];
`else
        head_ovf_next = 1'b0;
`endif
      end
    end
  end

  // Entry storage; no reset needed because only pushed slots are ever read.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem_s[wr_ptr]  <= in_s;
      mem_c8[wr_ptr] <= in_c8;
    end
  end

  // Pointers, occupancy and head registers; reset discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      head_s_q   <= '0;
      head_c8_q  <= 1'b0;
      head_ovf_q <= 1'b0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count_q    <= count_next;
      head_s_q   <= head_s_next;
      head_c8_q  <= head_c8_next;
      head_ovf_q <= head_ovf_next;
    end
  end

  // Saturating count of results offered while the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
